// File: rtl/wall_timer.sv
// Wall-clock timer: programmable prescaler, CNT_W-bit tick counter, compare unit raising a level irq.
// Register writes land on the strobe edge; reads return one cycle later on reg_rvalid; never stalls.
module wall_timer #(
  parameter int CNT_W   = 64,
  parameter int PRE_W   = 16,
  parameter int DEF_DIV = 1000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             reg_wen,
  input  logic             reg_ren,
  input  logic [2:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             reg_rvalid,
  output logic [CNT_W-1:0] cnt_val,
  output logic             tick,
  output logic             irq
);

  localparam int HI_W = CNT_W - 32;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_DIV    = 3'd1;
  localparam logic [2:0] A_CNT_LO = 3'd2;
  localparam logic [2:0] A_CNT_HI = 3'd3;
  localparam logic [2:0] A_CMP_LO = 3'd4;
  localparam logic [2:0] A_CMP_HI = 3'd5;
  localparam logic [2:0] A_PERIOD = 3'd6;
  localparam logic [2:0] A_STATUS = 3'd7;

  logic             en;
  logic             cmp_en;
  logic             periodic;
  logic [PRE_W-1:0] div;
  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cmp;
  logic [31:0]      period;
  logic             pend;
  logic [HI_W-1:0]  hi_shadow;

  logic             wr_ctrl, wr_div, wr_cnt_lo, wr_cnt_hi, wr_cnt;
  logic             wr_cmp_lo, wr_cmp_hi, wr_period, wr_status;
  logic [PRE_W-1:0] pre_last;
  logic             pre_wrap;
  logic             step;
  logic [CNT_W-1:0] cnt_inc;
  logic             match;
  logic [31:0]      rd_mux;

  assign wr_ctrl   = reg_wen && (reg_addr == A_CTRL);
  assign wr_div    = reg_wen && (reg_addr == A_DIV);
  assign wr_cnt_lo = reg_wen && (reg_addr == A_CNT_LO);
  assign wr_cnt_hi = reg_wen && (reg_addr == A_CNT_HI);
  assign wr_cmp_lo = reg_wen && (reg_addr == A_CMP_LO);
  assign wr_cmp_hi = reg_wen && (reg_addr == A_CMP_HI);
  assign wr_period = reg_wen && (reg_addr == A_PERIOD);
  assign wr_status = reg_wen && (reg_addr == A_STATUS);
  assign wr_cnt    = wr_cnt_lo || wr_cnt_hi;

  // DIV of 0 is treated as a divide-by-one.
  assign pre_last = (div == '0) ? '0 : div - PRE_W'(1);
  assign pre_wrap = en && (pre == pre_last);
  // A software counter write swallows the increment, the tick pulse and the compare.
  assign step     = pre_wrap && !wr_cnt;
  assign cnt_inc  = cnt + CNT_W'(1);
  assign match    = step && cmp_en && (cnt_inc == cmp);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      en       <= 1'b0;
      cmp_en   <= 1'b0;
      periodic <= 1'b0;
      div      <= PRE_W'(DEF_DIV);
      period   <= '0;
    end else begin
      if (wr_ctrl) begin
        en       <= reg_wdata[0];
        cmp_en   <= reg_wdata[1];
        periodic <= reg_wdata[2];
      end
      if (wr_div)    div    <= reg_wdata[PRE_W-1:0];
      if (wr_period) period <= reg_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre  <= '0;
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      if (wr_ctrl || wr_div || !en || pre_wrap) pre <= '0;
      else                                      pre <= pre + PRE_W'(1);

      if (wr_cnt_lo)      cnt[31:0]       <= reg_wdata;
      else if (wr_cnt_hi) cnt[CNT_W-1:32] <= reg_wdata[HI_W-1:0];
      else if (step)      cnt             <= cnt_inc;

      tick <= step;
    end
  end

  // A software CMP write wins over the periodic reload; a match wins over W1C.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmp  <= '1;
      pend <= 1'b0;
    end else begin
      if (wr_cmp_lo)               cmp[31:0]       <= reg_wdata;
      else if (wr_cmp_hi)          cmp[CNT_W-1:32] <= reg_wdata[HI_W-1:0];
      else if (match && periodic)  cmp             <= cmp + CNT_W'(period);

      if (match)                          pend <= 1'b1;
      else if (wr_status && reg_wdata[0]) pend <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      A_CTRL:   rd_mux = {29'd0, periodic, cmp_en, en};
      A_DIV:    rd_mux = 32'(div);
      A_CNT_LO: rd_mux = cnt[31:0];
      A_CNT_HI: rd_mux = 32'(hi_shadow);
      A_CMP_LO: rd_mux = cmp[31:0];
      A_CMP_HI: rd_mux = 32'(cmp[CNT_W-1:32]);
      A_PERIOD: rd_mux = period;
      A_STATUS: rd_mux = {31'd0, pend};
      default:  rd_mux = '0;
    endcase
  end

  // Reading LO snapshots the upper half so a later HI read pairs coherently.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reg_rdata  <= '0;
      reg_rvalid <= 1'b0;
      hi_shadow  <= '0;
    end else begin
      reg_rvalid <= reg_ren;
      if (reg_ren) reg_rdata <= rd_mux;
      if (reg_ren && (reg_addr == A_CNT_LO)) hi_shadow <= cnt[CNT_W-1:32];
    end
  end

  assign cnt_val = cnt;
  assign irq     = pend && cmp_en;

endmodule

// File: tb/tb_wall_timer.sv
// Self-checking bench for wall_timer: register table, directed timing sequences, randomized count/compare runs.
module tb_wall_timer;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_DIV    = 3'd1;
  localparam logic [2:0] A_CNT_LO = 3'd2;
  localparam logic [2:0] A_CNT_HI = 3'd3;
  localparam logic [2:0] A_CMP_LO = 3'd4;
  localparam logic [2:0] A_CMP_HI = 3'd5;
  localparam logic [2:0] A_PERIOD = 3'd6;
  localparam logic [2:0] A_STATUS = 3'd7;
  localparam int NV = 26;

  typedef struct {
    bit          is_wr;
    logic [2:0]  addr;
    logic [31:0] data;
  } vec_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        reg_wen = 1'b0;
  logic        reg_ren = 1'b0;
  logic [2:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        reg_rvalid;
  logic [63:0] cnt_val;
  logic        tick;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int tick_q[$];
  vec_t tbl [NV];

  wall_timer #(.CNT_W(64), .PRE_W(16), .DEF_DIV(1000)) dut (
    .clk(clk), .resetn(resetn), .reg_wen(reg_wen), .reg_ren(reg_ren),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .reg_rvalid(reg_rvalid), .cnt_val(cnt_val), .tick(tick), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tick === 1'b1) tick_q.push_back(cyc);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_wen = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk);
    reg_wen = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    reg_ren = 1'b1; reg_addr = a;
    @(negedge clk);
    reg_ren = 1'b0;
    d = reg_rdata;
    chk("rvalid", reg_rvalid, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    idle(2);
    resetn = 1'b1;
  endtask

  task automatic stop_and_load(input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] d);
    wr(A_CTRL, 0); wr(A_CNT_LO, lo); wr(A_CNT_HI, hi); wr(A_DIV, d);
  endtask

  initial begin
    logic [31:0] r;
    int e0;
    int bad;
    bit seen;

    tbl = '{
      '{1'b0, A_CTRL,   32'h0},        '{1'b0, A_DIV,    32'd1000},
      '{1'b0, A_CNT_LO, 32'h0},        '{1'b0, A_CNT_HI, 32'h0},
      '{1'b0, A_CMP_LO, 32'hFFFFFFFF}, '{1'b0, A_CMP_HI, 32'hFFFFFFFF},
      '{1'b0, A_PERIOD, 32'h0},        '{1'b0, A_STATUS, 32'h0},
      '{1'b1, A_DIV,    32'h000ABCDE}, '{1'b0, A_DIV,    32'h0000BCDE},
      '{1'b1, A_PERIOD, 32'h12345678}, '{1'b0, A_PERIOD, 32'h12345678},
      '{1'b1, A_CMP_LO, 32'h11223344}, '{1'b1, A_CMP_HI, 32'h55667788},
      '{1'b0, A_CMP_LO, 32'h11223344}, '{1'b0, A_CMP_HI, 32'h55667788},
      '{1'b1, A_CNT_LO, 32'hCAFEF00D}, '{1'b1, A_CNT_HI, 32'h0BADBEEF},
      '{1'b0, A_CNT_HI, 32'h0},        '{1'b0, A_CNT_LO, 32'hCAFEF00D},
      '{1'b0, A_CNT_HI, 32'h0BADBEEF}, '{1'b1, A_CTRL,   32'hFFFFFFF6},
      '{1'b0, A_CTRL,   32'h6},        '{1'b1, A_STATUS, 32'hFFFFFFFF},
      '{1'b0, A_STATUS, 32'h0},        '{1'b1, A_CTRL,   32'h0}
    };

    // Reset state of the outputs.
    idle(2);
    chk("rst_cnt", cnt_val, 0);
    chk("rst_tick", tick, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rvalid", reg_rvalid, 0);
    chk("rst_rdata", reg_rdata, 0);
    resetn = 1'b1;

    // Register defaults and write/read-back table.
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
      else begin
        rd(tbl[i].addr, r);
        chk($sformatf("tbl[%0d]", i), r, tbl[i].data);
      end
    end
    chk("tbl_cnt_val", cnt_val, 64'h0BADBEEF_CAFEF00D);
    chk("tbl_irq", irq, 0);

    // Default divider: three ticks exactly 1000 cycles apart.
    do_reset();
    tick_q.delete();
    wr(A_CTRL, 1);
    e0 = cyc;
    idle(3000);
    #1;
    chk("def_cnt", cnt_val, 3);
    chk("def_ntick", tick_q.size(), 3);
    if (tick_q.size() >= 3) begin
      chk("def_first", tick_q[0] - e0, 1000);
      chk("def_gap1", tick_q[1] - tick_q[0], 1000);
      chk("def_gap2", tick_q[2] - tick_q[1], 1000);
    end

    // Prescaler: DIV=0 and DIV=1 both count every cycle; DIV change restarts the phase.
    stop_and_load(0, 0, 0);
    wr(A_CTRL, 1);
    idle(5);
    chk("div0_cnt", cnt_val, 5);
    wr(A_DIV, 1);
    idle(5);
    chk("div1_cnt", cnt_val, 11);
    wr(A_DIV, 7);
    idle(3);
    chk("div7_cnt", cnt_val, 12);
    tick_q.delete();
    wr(A_DIV, 5);
    e0 = cyc;
    idle(8);
    #1;
    chk("div5_first", (tick_q.size() > 0) ? tick_q[0] - e0 : -1, 5);
    chk("div5_cnt", cnt_val, 13);

    // Coherent 64-bit read across a low-word rollover.
    stop_and_load(0, 32'hFFFFFFFC, 1);
    wr(A_CTRL, 1);
    idle(2);
    rd(A_CNT_LO, r);
    chk("coh_lo", r, 32'hFFFFFFFE);
    idle(5);
    chk("coh_live_hi", cnt_val[63:32], 1);
    rd(A_CNT_HI, r);
    chk("coh_hi", r, 0);

    // One-shot compare at 10.
    stop_and_load(0, 0, 1);
    wr(A_CMP_LO, 10); wr(A_CMP_HI, 0); wr(A_STATUS, 1);
    wr(A_CTRL, 3);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (cnt_val == 9) chk("os_irq_at9", irq, 0);
      if (cnt_val == 10) begin
        chk("os_irq_at10", irq, 1);
        seen = 1;
      end
    end
    chk("os_reach10", seen, 1);
    wr(A_STATUS, 1);
    chk("os_irq_clr", irq, 0);
    bad = 0;
    for (int i = 0; i < 60 && cnt_val < 50; i++) begin
      @(negedge clk);
      if (irq) bad++;
    end
    chk("os_no_reirq", bad, 0);
    chk("os_reach50", cnt_val >= 50, 1);
    rd(A_CMP_LO, r);
    chk("os_cmp_kept", r, 10);

    // Periodic compare every 4 counts at DIV=3; last match collides with a W1C.
    stop_and_load(0, 0, 3);
    wr(A_CMP_LO, 4); wr(A_CMP_HI, 0); wr(A_PERIOD, 4); wr(A_STATUS, 1);
    wr(A_CTRL, 7);
    e0 = cyc;
    for (int i = 0; i < 50 && !irq; i++) @(negedge clk);
    chk("per_irq1_cnt", cnt_val, 4);
    chk("per_irq1_cyc", cyc - e0, 12);
    wr(A_STATUS, 1);
    chk("per_clr1", irq, 0);
    for (int i = 0; i < 50 && !irq; i++) @(negedge clk);
    chk("per_irq2_cnt", cnt_val, 8);
    wr(A_STATUS, 1);
    chk("per_clr2", irq, 0);
    for (int i = 0; i < 100 && cyc != e0 + 35; i++) @(negedge clk);
    wr(A_STATUS, 1);
    chk("per_w1c_loses", irq, 1);
    chk("per_irq3_cnt", cnt_val, 12);
    rd(A_CMP_LO, r);
    chk("per_cmp_next", r, 16);

    // Counter write on a tick edge wins and suppresses the tick.
    stop_and_load(0, 0, 1);
    wr(A_CTRL, 1);
    idle(3);
    chk("cf_pre", cnt_val, 3);
    wr(A_CNT_LO, 100);
    chk("cf_cnt", cnt_val, 100);
    chk("cf_notick", tick, 0);
    @(negedge clk);
    chk("cf_next", cnt_val, 101);
    chk("cf_tick", tick, 1);

    // Asynchronous reset mid-count, with a read response outstanding.
    reg_ren = 1'b1; reg_addr = A_DIV;
    @(posedge clk);
    #2;
    reg_ren = 1'b0;
    chk("ar_rvalid_before", reg_rvalid, 1);
    resetn = 1'b0;
    #1;
    chk("ar_cnt", cnt_val, 0);
    chk("ar_tick", tick, 0);
    chk("ar_irq", irq, 0);
    chk("ar_rdata", reg_rdata, 0);
    chk("ar_rvalid", reg_rvalid, 0);
    @(negedge clk);
    resetn = 1'b1;
    rd(A_DIV, r);
    chk("ar_div", r, 1000);

    // Randomized: count = start + floor(M/N); irq once M >= k*N for CMP = start + k.
    for (int it = 0; it < 15; it++) begin
      logic [63:0] start, cmpv, expc;
      logic [31:0] lo, hi;
      int d, n, m, k;
      d = $urandom_range(0, 6);
      n = (d == 0) ? 1 : d;
      m = $urandom_range(0, 40);
      k = $urandom_range(1, 8);
      hi = $urandom;
      if (it % 3 == 0) hi = 32'hFFFFFFFF;
      lo = (it % 2 == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : 32'($urandom);
      start = {hi, lo};
      cmpv = start + 64'(k);
      wr(A_CTRL, 0); wr(A_CNT_LO, lo); wr(A_CNT_HI, hi);
      wr(A_CMP_LO, cmpv[31:0]); wr(A_CMP_HI, cmpv[63:32]);
      wr(A_DIV, d); wr(A_STATUS, 1);
      wr(A_CTRL, 3);
      idle(m);
      expc = start + 64'(m / n);
      chk($sformatf("rnd%0d_cnt", it), cnt_val, expc);
      chk($sformatf("rnd%0d_irq", it), irq, (m >= k * n));
      rd(A_CNT_LO, r);
      chk($sformatf("rnd%0d_lo", it), r, expc[31:0]);
      rd(A_CNT_HI, r);
      chk($sformatf("rnd%0d_hi", it), r, expc[63:32]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
